// File: rtl/serial_word_receiver_if.sv
// Handshake and serial-line bundle between the link driver (master) and the
// serial_word_receiver (slave).
interface serial_word_receiver_if #(
  parameter int unsigned WIDTH = 4
);
  logic             sin;
  logic             sin_en;
  logic             lsb_first;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             frame_err;
  logic             overrun;
  logic             busy;

  modport master (
    output sin, sin_en, lsb_first, dout_ready,
    input  dout, dout_valid, frame_err, overrun, busy
  );

  modport slave (
    input  sin, sin_en, lsb_first, dout_ready,
    output dout, dout_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Framed serial receiver: start 0, WIDTH data bits, stop 1, sampled on sin_en.
// Delivers words over valid/ready and pulses frame_err / overrun.
module serial_word_receiver #(
  parameter int unsigned WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_word_receiver_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;

  state_t             r_state, w_state_nx;
  logic [WIDTH-1:0]   r_sr, w_sr_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic               r_dir, w_dir_nx;
  logic [WIDTH-1:0]   r_dout, w_dout_nx;
  logic               r_valid, w_valid_nx;
  logic               r_ferr, w_ferr_nx;
  logic               r_ovr, w_ovr_nx;
  logic               r_busy, w_busy_nx;

  always_comb begin
    w_state_nx = r_state;
    w_sr_nx    = r_sr;
    w_cnt_nx   = r_cnt;
    w_dir_nx   = r_dir;
    w_dout_nx  = r_dout;
    w_valid_nx = r_valid & ~bus.dout_ready;
    w_ferr_nx  = 1'b0;
    w_ovr_nx   = 1'b0;
    if (bus.sin_en) begin
      case (r_state)
        S_IDLE: begin
          if (!bus.sin) begin
            w_state_nx = S_DATA;
            w_cnt_nx   = '0;
            w_dir_nx   = bus.lsb_first;
          end
        end
        S_DATA: begin
          if (r_dir) w_sr_nx = {bus.sin, r_sr[WIDTH-1:1]};
          else       w_sr_nx = {r_sr[WIDTH-2:0], bus.sin};
          w_cnt_nx = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nx = S_STOP;
        end
        S_STOP: begin
          // A bad stop bit returns to IDLE without being reused as a start bit.
          w_state_nx = S_IDLE;
          if (!bus.sin) begin
            w_ferr_nx = 1'b1;
          end else if (!r_valid || bus.dout_ready) begin
            w_dout_nx  = r_sr;
            w_valid_nx = 1'b1;
          end else begin
            w_ovr_nx = 1'b1;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_sr    <= w_sr_nx;
      r_cnt   <= w_cnt_nx;
      r_dir   <= w_dir_nx;
      r_dout  <= w_dout_nx;
      r_valid <= w_valid_nx;
      r_ferr  <= w_ferr_nx;
      r_ovr   <= w_ovr_nx;
      r_busy  <= w_busy_nx;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.frame_err  = r_ferr;
  assign bus.overrun    = r_ovr;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver with a frame-level reference model
// and per-cycle output comparison.
module tb_serial_word_receiver;
  localparam int unsigned W = 4;

  typedef enum int {A_NONE, A_START, A_DATA, A_GOOD, A_BAD} ann_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  serial_word_receiver_if #(.WIDTH(W)) bus ();

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Driver annotation of what the current strobe means at frame level.
  ann_t         ann = A_NONE;
  logic [W-1:0] ann_word = '0;

  // Reference model: word-level state only.
  logic [W-1:0] m_dout = '0;
  logic         m_valid = 1'b0;
  logic         m_ferr = 1'b0;
  logic         m_ovr = 1'b0;
  logic         m_busy = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dout = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
    end else begin
      logic was_valid;
      logic rdy;
      was_valid = m_valid;
      rdy       = bus.dout_ready;
      m_ferr    = 1'b0;
      m_ovr     = 1'b0;
      if (was_valid && rdy) m_valid = 1'b0;
      case (ann)
        A_START: m_busy = 1'b1;
        A_GOOD: begin
          m_busy = 1'b0;
          if (!was_valid || rdy) begin
            m_dout  = ann_word;
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end
        A_BAD: begin
          m_busy = 1'b0;
          m_ferr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if (bus.dout !== m_dout || bus.dout_valid !== m_valid || bus.frame_err !== m_ferr ||
          bus.overrun !== m_ovr || bus.busy !== m_busy) begin
        miscompares++;
        $display("FAIL cycle_cmp t=%0t: got dout=%h v=%b fe=%b ov=%b busy=%b, want dout=%h v=%b fe=%b ov=%b busy=%b",
                 $time, bus.dout, bus.dout_valid, bus.frame_err, bus.overrun, bus.busy,
                 m_dout, m_valid, m_ferr, m_ovr, m_busy);
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic b, input ann_t a, input logic [W-1:0] w, input int gap);
    repeat (gap) @(negedge clk);
    bus.sin    = b;
    bus.sin_en = 1'b1;
    ann        = a;
    ann_word   = w;
    @(negedge clk);
    bus.sin_en = 1'b0;
    bus.sin    = 1'b1;
    ann        = A_NONE;
  endtask

  // bits[i] is the i-th data bit on the wire.
  task automatic send_frame(input logic [W-1:0] bits, input logic stop, input int gap,
                            input logic toggle, input logic rdy_at_stop);
    logic         dir;
    logic [W-1:0] word;
    dir = bus.lsb_first;
    for (int i = 0; i < W; i++) begin
      if (dir) word[i] = bits[i];
      else     word[W-1-i] = bits[i];
    end
    strobe(1'b0, A_START, '0, gap);
    for (int i = 0; i < W; i++) begin
      if (toggle && i == 2) bus.lsb_first = ~bus.lsb_first;
      strobe(bits[i], A_DATA, '0, gap);
    end
    if (rdy_at_stop) bus.dout_ready = 1'b1;
    strobe(stop, stop ? A_GOOD : A_BAD, word, gap);
  endtask

  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    bus.sin = 1'b1; bus.sin_en = 1'b0; bus.lsb_first = 1'b1; bus.dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_dout", bus.dout, 4'h0);
    chk("reset_valid", {3'b0, bus.dout_valid}, 4'h0);
    chk("reset_busy", {3'b0, bus.busy}, 4'h0);

    // 1: LSB-first, bits 1,1,0,1
    send_frame(4'b1011, 1'b1, 0, 1'b0, 1'b0);
    chk("t1_dout", bus.dout, 4'b1011);
    chk("t1_valid", {3'b0, bus.dout_valid}, 4'h1);
    @(negedge clk);
    chk("t1_valid_pulse", {3'b0, bus.dout_valid}, 4'h0);

    // 2: MSB-first, plain then with lsb_first toggled mid-frame
    bus.lsb_first = 1'b0;
    send_frame(4'b1011, 1'b1, 0, 1'b0, 1'b0);
    chk("t2_dout", bus.dout, 4'b1101);
    bus.lsb_first = 1'b0;
    send_frame(4'b1011, 1'b1, 1, 1'b1, 1'b0);
    chk("t2_toggle_dout", bus.dout, 4'b1101);

    // 3: bad stop bit, then a good frame
    bus.lsb_first = 1'b1;
    send_frame(4'b0101, 1'b0, 0, 1'b0, 1'b0);
    chk("t3_ferr", {3'b0, bus.frame_err}, 4'h1);
    chk("t3_valid", {3'b0, bus.dout_valid}, 4'h0);
    chk("t3_busy", {3'b0, bus.busy}, 4'h0);
    send_frame(4'b0110, 1'b1, 0, 1'b0, 1'b0);
    chk("t3_next_dout", bus.dout, 4'h6);

    // 4: overrun with ready low
    @(negedge clk);
    bus.dout_ready = 1'b0;
    send_frame(4'hA, 1'b1, 0, 1'b0, 1'b0);
    send_frame(4'h5, 1'b1, 0, 1'b0, 1'b0);
    chk("t4_ovr", {3'b0, bus.overrun}, 4'h1);
    chk("t4_dout_held", bus.dout, 4'hA);
    bus.dout_ready = 1'b1;
    @(negedge clk);
    chk("t4_drained", {3'b0, bus.dout_valid}, 4'h0);
    bus.dout_ready = 1'b0;

    // 5: ready coincides with second stop bit
    send_frame(4'hA, 1'b1, 0, 1'b0, 1'b0);
    send_frame(4'h5, 1'b1, 0, 1'b0, 1'b1);
    bus.dout_ready = 1'b0;
    chk("t5_dout", bus.dout, 4'h5);
    chk("t5_valid", {3'b0, bus.dout_valid}, 4'h1);
    chk("t5_no_ovr", {3'b0, bus.overrun}, 4'h0);

    // 6: async reset mid-frame with a word still pending
    strobe(1'b0, A_START, '0, 0);
    strobe(1'b1, A_DATA, '0, 0);
    strobe(1'b0, A_DATA, '0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dout", bus.dout, 4'h0);
    chk("t6_rst_valid", {3'b0, bus.dout_valid}, 4'h0);
    chk("t6_rst_busy", {3'b0, bus.busy}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.dout_ready = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 6; g++) begin
      send_frame(4'h3, 1'b1, g, 1'b0, 1'b0);
      chk("t6_gap_dout", bus.dout, 4'h3);
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
